// File: rtl/t1_sim_ctrl_pkg.sv
// Shared types and constants for the T1 simulation-control sequencer.
package t1_sim_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAIL  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_WATCHDOG   = 2'd1,
      CAUSE_IDLE_TMO   = 2'd2,
      CAUSE_GLOBAL_TMO = 2'd3
   } fail_cause_e;

   localparam logic [7:0] WD_CONTINUE = 8'd0;
   localparam logic [7:0] WD_QUIT     = 8'd255;

endpackage

// File: rtl/t1_sim_dump_window.sv
// Waveform dump window: set when the count reaches start, cleared at end.
// i_cycle is the count being loaded into the cycle register on this edge,
// so o_dump_on lines up with the post-edge cycle value seen by the harness.
module t1_sim_dump_window
   import t1_sim_ctrl_pkg::*;
#(
   parameter int unsigned CYCLE_W = 64
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [CYCLE_W-1:0] i_cycle,
   input  logic [CYCLE_W-1:0] i_start,
   input  logic [CYCLE_W-1:0] i_end,
   output logic               o_dump_on
);

   logic w_set;
   logic w_clr;
   logic r_dump_on;

   // Set/clear comparators; an end value of zero never clears.
   always_comb begin
      w_set = (i_cycle == i_start);
      w_clr = (i_end != '0) && (i_cycle == i_end);
   end

   // Window register; clear wins over a coincident set.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_dump_on <= (i_start == '0);
      end else if (w_clr) begin
         r_dump_on <= 1'b0;
      end else if (w_set) begin
         r_dump_on <= 1'b1;
      end
   end

   assign o_dump_on = r_dump_on;

endmodule

// File: rtl/t1_sim_ctrl.sv
// T1 simulation-control sequencer: reset/init sequencing, watchdog polling,
// post-quit drain, global timeout and dump window, with a sticky verdict.
module t1_sim_ctrl
   import t1_sim_ctrl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 5,
   parameter int unsigned INIT_CYCLES  = 1,
   parameter int unsigned CYCLE_W      = 64
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [CYCLE_W-1:0] cfg_global_timeout,
   input  logic [CYCLE_W-1:0] cfg_timeout_after_quit,
   input  logic [CYCLE_W-1:0] cfg_dump_start,
   input  logic [CYCLE_W-1:0] cfg_dump_end,
   input  logic               wd_valid,
   input  logic [7:0]         wd_status,
   input  logic               idle,
   output logic               core_reset,
   output logic               init_flag,
   output logic               wd_poll,
   output logic               dump_on,
   output logic               done,
   output logic               fail,
   output logic [1:0]         fail_cause,
   output logic [CYCLE_W-1:0] cycle
);

   state_e             r_state;
   state_e             w_state_nxt;
   fail_cause_e        r_cause;
   fail_cause_e        w_cause_nxt;
   logic [CYCLE_W-1:0] r_cycle;
   logic [CYCLE_W-1:0] w_cycle_nxt;
   logic [CYCLE_W-1:0] r_quit_cycle;
   logic               w_quit_ld;
   logic [CYCLE_W:0]   w_idle_limit;
   logic               w_idle_tmo;
   logic               w_global_tmo;
   logic               w_wd_quit;
   logic               w_wd_err;
   logic               r_core_reset;
   logic               r_init_flag;
   logic               r_done;
   logic               r_fail;

   // Saturating cycle count for the upcoming edge.
   always_comb begin
      w_cycle_nxt = (r_cycle == '1) ? r_cycle : r_cycle + 1'b1;
   end

   // Next-state and cause decode; comparisons use the current cycle value.
   // A quit with busy DUT loses to a coincident global timeout, since the
   // equality compare would otherwise never fire again from DRAIN.
   always_comb begin
      w_state_nxt  = r_state;
      w_cause_nxt  = r_cause;
      w_quit_ld    = 1'b0;
      w_idle_limit = {1'b0, r_quit_cycle} + {1'b0, cfg_timeout_after_quit};
      w_idle_tmo   = ({1'b0, r_cycle} > w_idle_limit);
      w_global_tmo = (cfg_global_timeout != '0) && (r_cycle == cfg_global_timeout);
      w_wd_quit    = wd_valid && (wd_status == WD_QUIT);
      w_wd_err     = wd_valid && (wd_status != WD_QUIT) && (wd_status != WD_CONTINUE);
      case (r_state)
         ST_HOLD: begin
            if (w_cycle_nxt >= CYCLE_W'(RESET_CYCLES)) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_wd_quit && idle) begin
               w_state_nxt = ST_DONE;
            end else if (w_wd_err) begin
               w_state_nxt = ST_FAIL;
               w_cause_nxt = CAUSE_WATCHDOG;
            end else if (w_global_tmo) begin
               w_state_nxt = ST_FAIL;
               w_cause_nxt = CAUSE_GLOBAL_TMO;
            end else if (w_wd_quit) begin
               w_state_nxt = ST_DRAIN;
               w_quit_ld   = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (idle) begin
               w_state_nxt = ST_DONE;
            end else if (w_idle_tmo) begin
               w_state_nxt = ST_FAIL;
               w_cause_nxt = CAUSE_IDLE_TMO;
            end else if (w_global_tmo) begin
               w_state_nxt = ST_FAIL;
               w_cause_nxt = CAUSE_GLOBAL_TMO;
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
   end

   // State, counter, quit latch and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_HOLD;
         r_cause      <= CAUSE_NONE;
         r_cycle      <= '0;
         r_quit_cycle <= '0;
         r_core_reset <= 1'b1;
         r_init_flag  <= 1'b1;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cause      <= w_cause_nxt;
         r_cycle      <= w_cycle_nxt;
         if (w_quit_ld) begin
            r_quit_cycle <= r_cycle;
         end
         r_core_reset <= (w_state_nxt == ST_HOLD);
         r_init_flag  <= (w_cycle_nxt < CYCLE_W'(INIT_CYCLES));
         r_done       <= (w_state_nxt == ST_DONE);
         r_fail       <= (w_state_nxt == ST_FAIL);
      end
   end

   t1_sim_dump_window #(
      .CYCLE_W (CYCLE_W)
   ) u_dump_window (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_cycle   (w_cycle_nxt),
      .i_start   (cfg_dump_start),
      .i_end     (cfg_dump_end),
      .o_dump_on (dump_on)
   );

   assign wd_poll    = (r_state == ST_RUN);
   assign core_reset = r_core_reset;
   assign init_flag  = r_init_flag;
   assign done       = r_done;
   assign fail       = r_fail;
   assign fail_cause = r_cause;
   assign cycle      = r_cycle;

endmodule

// File: tb/tb_t1_sim_ctrl.sv
// Scoreboard bench for t1_sim_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor compares them when the DUT cycle count reaches them.
module tb_t1_sim_ctrl;

   typedef enum int {K_CRST, K_INIT, K_POLL, K_DUMP, K_DONE, K_FAIL, K_CAUSE} kind_e;

   typedef struct {
      logic [63:0] cyc;
      kind_e       kind;
      logic [63:0] val;
   } exp_t;

   logic        clock;
   logic        reset;
   logic [63:0] cfg_global_timeout;
   logic [63:0] cfg_timeout_after_quit;
   logic [63:0] cfg_dump_start;
   logic [63:0] cfg_dump_end;
   logic        wd_valid;
   logic [7:0]  wd_status;
   logic        idle;
   logic        core_reset;
   logic        init_flag;
   logic        wd_poll;
   logic        dump_on;
   logic        done;
   logic        fail;
   logic [1:0]  fail_cause;
   logic [63:0] cycle;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   t1_sim_ctrl #(
      .RESET_CYCLES (5),
      .INIT_CYCLES  (1),
      .CYCLE_W      (64)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .cfg_global_timeout     (cfg_global_timeout),
      .cfg_timeout_after_quit (cfg_timeout_after_quit),
      .cfg_dump_start         (cfg_dump_start),
      .cfg_dump_end           (cfg_dump_end),
      .wd_valid               (wd_valid),
      .wd_status              (wd_status),
      .idle                   (idle),
      .core_reset             (core_reset),
      .init_flag              (init_flag),
      .wd_poll                (wd_poll),
      .dump_on                (dump_on),
      .done                   (done),
      .fail                   (fail),
      .fail_cause             (fail_cause),
      .cycle                  (cycle)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic string kname(kind_e k);
      case (k)
         K_CRST:  return "core_reset";
         K_INIT:  return "init_flag";
         K_POLL:  return "wd_poll";
         K_DUMP:  return "dump_on";
         K_DONE:  return "done";
         K_FAIL:  return "fail";
         K_CAUSE: return "fail_cause";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [63:0] sample(kind_e k);
      case (k)
         K_CRST:  return {63'd0, core_reset};
         K_INIT:  return {63'd0, init_flag};
         K_POLL:  return {63'd0, wd_poll};
         K_DUMP:  return {63'd0, dump_on};
         K_DONE:  return {63'd0, done};
         K_FAIL:  return {63'd0, fail};
         K_CAUSE: return {62'd0, fail_cause};
         default: return '0;
      endcase
   endfunction

   task automatic expect_at(input logic [63:0] c, input kind_e k, input logic [63:0] v);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.val  = v;
      sb.push_back(e);
   endtask

   // Monitor: compare every queued expectation whose cycle has arrived.
   always @(negedge clock) begin
      for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
         if (sb[i].cyc < cycle) begin
            errors++;
            checks++;
            $display("FAIL %s missed: expected at cycle %0d, dut now at cycle %0d (required %0d)",
                     kname(sb[i].kind), sb[i].cyc, cycle, sb[i].val);
            sb.delete(i);
         end else if (sb[i].cyc == cycle) begin
            checks++;
            if (sample(sb[i].kind) !== sb[i].val) begin
               errors++;
               $display("FAIL %s @cycle %0d: got %0d required %0d",
                        kname(sb[i].kind), cycle, sample(sb[i].kind), sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   // Must be called at a negedge; bounded wait for the DUT count to reach n.
   task automatic wait_cycle(input logic [63:0] n);
      int unsigned k;
      k = 0;
      while (cycle != n && k < 300) begin
         @(negedge clock);
         k++;
      end
      if (cycle != n) begin
         errors++;
         checks++;
         $display("FAIL wait_cycle: got cycle %0d required %0d", cycle, n);
      end
   endtask

   task automatic wd_pulse(input logic [63:0] n, input logic [7:0] st, input logic idl);
      wait_cycle(n);
      wd_valid  = 1'b1;
      wd_status = st;
      idle      = idl;
      @(negedge clock);
      wd_valid  = 1'b0;
      wd_status = 8'd0;
   endtask

   // Assert reset between edges and queue the reset-state expectations.
   task automatic start_test(input logic [63:0] gto, input logic [63:0] tq,
                             input logic [63:0] ds, input logic [63:0] de);
      cfg_global_timeout     = gto;
      cfg_timeout_after_quit = tq;
      cfg_dump_start         = ds;
      cfg_dump_end           = de;
      @(posedge clock);
      #2;
      reset     = 1'b0;
      wd_valid  = 1'b0;
      wd_status = 8'd0;
      idle      = 1'b0;
      expect_at(0, K_CRST, 1);
      expect_at(0, K_INIT, 1);
      expect_at(0, K_POLL, 0);
      expect_at(0, K_DONE, 0);
      expect_at(0, K_FAIL, 0);
      expect_at(0, K_CAUSE, 0);
      expect_at(0, K_DUMP, (ds == 0) ? 64'd1 : 64'd0);
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic finish_test(input logic [63:0] last);
      wait_cycle(last);
      @(negedge clock);
      while (sb.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL %s never compared: cycle %0d required %0d",
                  kname(sb[0].kind), sb[0].cyc, sb[0].val);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout: simulation did not reach its end");
      $fatal(1, "time limit");
   end

   initial begin
      reset                  = 1'b0;
      wd_valid               = 1'b0;
      wd_status              = 8'd0;
      idle                   = 1'b0;
      cfg_global_timeout     = '0;
      cfg_timeout_after_quit = '0;
      cfg_dump_start         = '0;
      cfg_dump_end           = '0;

      // Reset sequence, continue status, clean quit; dump always on
      start_test(0, 10, 0, 0);
      expect_at(1, K_INIT, 0);
      expect_at(1, K_CRST, 1);
      expect_at(1, K_POLL, 0);
      expect_at(4, K_CRST, 1);
      expect_at(4, K_POLL, 0);
      expect_at(5, K_CRST, 0);
      expect_at(5, K_POLL, 1);
      expect_at(3, K_DUMP, 1);
      expect_at(11, K_DONE, 0);
      expect_at(11, K_FAIL, 0);
      expect_at(11, K_POLL, 1);
      expect_at(20, K_DONE, 0);
      expect_at(21, K_DONE, 1);
      expect_at(21, K_FAIL, 0);
      expect_at(21, K_CAUSE, 0);
      expect_at(21, K_POLL, 0);
      expect_at(25, K_DONE, 1);
      expect_at(25, K_POLL, 0);
      expect_at(50, K_DUMP, 1);
      release_reset();
      wd_pulse(10, 8'd0, 1'b0);
      wd_pulse(20, 8'd255, 1'b1);
      finish_test(50);

      // Drain to done; watchdog ignored in drain; dump window 8..11
      start_test(0, 10, 8, 12);
      expect_at(7, K_DUMP, 0);
      expect_at(8, K_DUMP, 1);
      expect_at(11, K_DUMP, 1);
      expect_at(12, K_DUMP, 0);
      expect_at(13, K_DUMP, 0);
      expect_at(21, K_POLL, 0);
      expect_at(21, K_DONE, 0);
      expect_at(25, K_FAIL, 0);
      expect_at(28, K_DONE, 0);
      expect_at(29, K_DONE, 1);
      expect_at(29, K_FAIL, 0);
      expect_at(29, K_CAUSE, 0);
      release_reset();
      wd_pulse(20, 8'd255, 1'b0);
      wd_pulse(24, 8'd3, 1'b0);
      wait_cycle(28);
      idle = 1'b1;
      finish_test(30);

      // Drain timeout; start == end so dump never on
      start_test(0, 10, 8, 8);
      expect_at(8, K_DUMP, 0);
      expect_at(9, K_DUMP, 0);
      expect_at(21, K_POLL, 0);
      expect_at(31, K_FAIL, 0);
      expect_at(32, K_FAIL, 1);
      expect_at(32, K_CAUSE, 2);
      expect_at(32, K_DONE, 0);
      release_reset();
      wd_pulse(20, 8'd255, 1'b0);
      finish_test(33);

      // Watchdog error status (also checks async clear of sticky fail)
      start_test(0, 10, 0, 0);
      expect_at(40, K_FAIL, 0);
      expect_at(40, K_POLL, 1);
      expect_at(41, K_FAIL, 1);
      expect_at(41, K_CAUSE, 1);
      expect_at(41, K_DONE, 0);
      expect_at(41, K_POLL, 0);
      release_reset();
      wd_pulse(40, 8'd3, 1'b0);
      finish_test(42);

      // Clean quit beats global timeout in the same cycle
      start_test(40, 10, 0, 0);
      expect_at(41, K_DONE, 1);
      expect_at(41, K_FAIL, 0);
      expect_at(41, K_CAUSE, 0);
      expect_at(45, K_FAIL, 0);
      release_reset();
      wd_pulse(40, 8'd255, 1'b1);
      finish_test(45);

      // Global timeout in RUN
      start_test(30, 10, 0, 0);
      expect_at(30, K_FAIL, 0);
      expect_at(30, K_POLL, 1);
      expect_at(31, K_FAIL, 1);
      expect_at(31, K_CAUSE, 3);
      expect_at(31, K_POLL, 0);
      release_reset();
      finish_test(32);

      // Idle timeout beats global timeout on the same cycle
      start_test(26, 5, 0, 0);
      expect_at(26, K_FAIL, 0);
      expect_at(27, K_FAIL, 1);
      expect_at(27, K_CAUSE, 2);
      release_reset();
      wd_pulse(20, 8'd255, 1'b0);
      finish_test(28);

      // Final reset clears the sticky verdict
      start_test(0, 10, 5, 0);
      finish_test(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/t1_sim_ctrl.md
# t1_sim_ctrl

Synthesizable simulation-control sequencer for the T1 testbench top. It counts cycles, sequences the DUT reset and init pulse, polls the cosim watchdog, runs the post-quit drain/idle check, enforces the global timeout and computes the waveform dump window. It raises a single terminal `done`/`fail` indication with a cause code for the surrounding harness to act on. It sits between the clock/reset generator and the DUT/DPI shims; the harness keeps only clock generation and `$finish`/`$fatal`.

## Interface
- `RESET_CYCLES`, default 5: cycles `core_reset` is held after `reset` release.
- `INIT_CYCLES`, default 1: cycles `init_flag` is held after `reset` release.
- `CYCLE_W`, default 64: width of the cycle counter and all cycle configuration inputs.
- `clock`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-low reset.
- `cfg_global_timeout`  in  CYCLE_W: 0 disables the global timeout.
- `cfg_timeout_after_quit`  in  CYCLE_W: drain budget after quit.
- `cfg_dump_start`  in  CYCLE_W: 0 means dump from reset release.
- `cfg_dump_end`  in  CYCLE_W: 0 means never stop.
- `wd_valid`  in  1: `wd_status` is valid this cycle.
- `wd_status`  in  8: watchdog result. 0 = continue, 255 = quit, other values = error.
- `idle`  in  1: DUT idle.
- `core_reset`  out  1: active-high reset to the DUT.
- `init_flag`  out  1: init pulse to the DUT.
- `wd_poll`  out  1: request a watchdog call this cycle.
- `dump_on`  out  1: waveform dump enable.
- `done`  out  1: successful termination. Sticky.
- `fail`  out  1: failed termination. Sticky.
- `fail_cause`  out  2: 0 = none, 1 = WATCHDOG, 2 = IDLE_TMO, 3 = GLOBAL_TMO.
- `cycle`  out  CYCLE_W: cycles since `reset` release.

## Operation
- **States:** HOLD → RUN → DRAIN → DONE or FAIL. DONE and FAIL are terminal until `reset`.
- **HOLD**
  - `core_reset=1` until `cycle==RESET_CYCLES`.
  - `init_flag=1` while `cycle<INIT_CYCLES`.
  - Exit to RUN when `cycle==RESET_CYCLES`.
- **RUN**
  - `wd_poll=1` every cycle.
  - On `wd_valid`:
    - status 0: no action.
    - status 255 and `idle`: → DONE.
    - status 255 and not `idle`: latch `quit_cycle=cycle`, → DRAIN.
    - any other status: → FAIL, cause WATCHDOG.
  - No `wd_valid`: no action.
- **DRAIN**
  - `wd_poll=0`; `wd_valid` is ignored.
  - `idle` → DONE.
  - Else if `cycle > quit_cycle + cfg_timeout_after_quit` → FAIL, cause IDLE_TMO. The sum is computed at CYCLE_W+1 bits, so it never wraps.
- **Global timeout:** in RUN or DRAIN, if `cfg_global_timeout!=0` and `cycle==cfg_global_timeout` → FAIL, cause GLOBAL_TMO.
- **Priority within one cycle:** DONE > WATCHDOG / IDLE_TMO > GLOBAL_TMO.
- **Cycle counter:** increments every clock from reset release, saturates at all-ones, and keeps counting in DONE/FAIL.
- **Dump window**
  - `dump_on` sets when `cycle==cfg_dump_start`; it is already set at reset release if `cfg_dump_start==0`.
  - It clears when `cfg_dump_end!=0` and `cycle==cfg_dump_end`.
  - If set and clear coincide, clear wins.
  - The window is independent of the FSM state.
- **Configuration inputs:** must be stable from reset release onward. Changes mid-run take effect on the next compare and carry no other guarantee.

## Timing
- **Reset values (while `reset` is low):**
  - `core_reset=1`, `init_flag=1`.
  - `wd_poll=0`, `done=0`, `fail=0`, `fail_cause=0`.
  - `cycle=0`.
  - `dump_on = (cfg_dump_start==0)`.
  - State HOLD.
- **Reset assertion mid-operation:** asynchronously returns every output to the reset values above in the same instant, including sticky `done`/`fail`.
- **Output registering:**
  - All outputs are registered except `wd_poll`, which is decoded combinationally from state.
  - `cycle` shows the post-edge count.
- **Latencies:**
  - A `wd_status` sampled at edge N drives `done`/`fail` high after edge N (1-cycle latency).
  - `idle` in DRAIN has the same 1-cycle latency.
- **Timeout boundary:** the first cycle eligible for IDLE_TMO is `quit_cycle + cfg_timeout_after_quit + 1`.

## Structure
- **Package `t1_sim_ctrl_pkg`:**
  - `state_e` enum.
  - `fail_cause_e` enum.
  - Constants `WD_CONTINUE=8'd0`, `WD_QUIT=8'd255`.
- **Sub-module `t1_sim_dump_window`:** holds the `dump_on` set/clear comparators. Parameter CYCLE_W; inputs clock, reset, cycle, start, end.
- **Top:** instantiates the window sub-module; FSM, counter and quit latch live in the top.

## Test plan
- **Reset sequence:** release `reset`; `wd_valid=0` → `init_flag` high only at cycle 0, `core_reset` drops at cycle 5, `wd_poll` high from cycle 5.
- **Clean quit:** status 255 with `idle=1` at cycle 20 → `done=1` at cycle 21, `fail=0`, `wd_poll=0` afterwards.
- **Drain to done:** status 255 with `idle=0` at cycle 20; `cfg_timeout_after_quit=10`; `idle` rises at cycle 28 → `done` at 29.
- **Drain timeout:** same as drain to done but `idle` never rises → `fail=1`, `fail_cause=2` after cycle 31.
- **Watchdog error and priority:**
  - status 3 at cycle 40 → `fail=1`, cause 1.
  - Separately, `cfg_global_timeout=40` with status 255 and `idle=1` at cycle 40 → `done=1`, no fail.
- **Dump window:** start=8, end=12 → `dump_on` high for cycles 8–11. Start=end=8 → `dump_on` never high. Start=0, end=0 → always high.
